// File: rtl/exception_sequencer.sv
// rtl/exception_sequencer.sv - exception/ERET control sequencer between detector and CP0/fetch
//
// Captures one exception request, holds flush for FLUSH_CYCLES, then commits
// EPC, Cause, Status and (for address errors) BadVAddr through CP0's single
// write port, one register per cycle, before redirecting fetch to HANDLER_VEC.
// ERET clears Status.EXL and redirects fetch to the current EPC.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   except_req        exception pending from the detector
//   exc_cause         Cause value to commit (ExcCode = exc_cause[6:2])
//   exc_status        Status value to commit (EXL not yet set)
//   exc_badpc         EPC value to commit
//   exc_badaddr       BadVAddr value to commit
//   eret              ERET retiring this cycle
//   epc_q, status_q   current CP0 EPC / Status contents
//   busy              sequencer active; front end must stall
//   flush             kill all in-flight instructions
//   cp0_we/waddr/wdata CP0 single write port
//   pc_redirect       one-cycle fetch redirect strobe
//   redirect_pc       redirect target
//   exl               internal copy of Status.EXL

module exception_sequencer #(
    parameter logic [31:0] HANDLER_VEC  = 32'h00400004,
    parameter int          FLUSH_CYCLES = 2,
    parameter int          EXL_BIT      = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        except_req,
    input  logic [31:0] exc_cause,
    input  logic [31:0] exc_status,
    input  logic [31:0] exc_badpc,
    input  logic [31:0] exc_badaddr,
    input  logic        eret,
    input  logic [31:0] epc_q,
    input  logic [31:0] status_q,
    output logic        busy,
    output logic        flush,
    output logic        cp0_we,
    output logic [4:0]  cp0_waddr,
    output logic [31:0] cp0_wdata,
    output logic        pc_redirect,
    output logic [31:0] redirect_pc,
    output logic        exl
);

    typedef enum logic [3:0] {
        IDLE,
        FLUSH,
        W_EPC,
        W_CAUSE,
        W_STATUS,
        W_BADV,
        REDIR,
        E_STATUS,
        E_REDIR
    } state_t;

    localparam logic [4:0]  REG_BADV   = 5'd8;
    localparam logic [4:0]  REG_STATUS = 5'd12;
    localparam logic [4:0]  REG_CAUSE  = 5'd13;
    localparam logic [4:0]  REG_EPC    = 5'd14;
    localparam logic [31:0] EXL_MASK   = 32'h1 << EXL_BIT;
    localparam logic [7:0]  CNT_INIT   = 8'(FLUSH_CYCLES - 1);

    state_t      state;
    logic [7:0]  cnt;
    logic        skip_epc;
    logic [31:0] cap_cause;
    logic [31:0] cap_status;
    logic [31:0] cap_badpc;
    logic [31:0] cap_badaddr;
    logic [31:0] cap_epc;

    logic [4:0]  req_code;
    logic [4:0]  cap_code;
    logic        req_masked;

    assign req_code   = exc_cause[6:2];
    assign cap_code   = cap_cause[6:2];
    // An interrupt (ExcCode 0) arriving while EXL is set is dropped outright.
    assign req_masked = exl && (req_code == 5'd0);

    // Outputs are registered from the state being left, so each state's
    // outputs appear for the cycle after the edge that leaves it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            skip_epc    <= 1'b0;
            cap_cause   <= '0;
            cap_status  <= '0;
            cap_badpc   <= '0;
            cap_badaddr <= '0;
            cap_epc     <= '0;
            exl         <= 1'b0;
            busy        <= 1'b0;
            flush       <= 1'b0;
            cp0_we      <= 1'b0;
            cp0_waddr   <= '0;
            cp0_wdata   <= '0;
            pc_redirect <= 1'b0;
            redirect_pc <= '0;
        end else begin
            busy        <= (state != IDLE);
            flush       <= 1'b0;
            cp0_we      <= 1'b0;
            cp0_waddr   <= '0;
            cp0_wdata   <= '0;
            pc_redirect <= 1'b0;
            redirect_pc <= '0;

            case (state)
                IDLE: begin
                    // Exception takes priority; a colliding eret is dropped.
                    // A masked interrupt is ignored, so an eret with it still runs.
                    if (except_req && !req_masked) begin
                        cap_cause   <= exc_cause;
                        cap_status  <= exc_status;
                        cap_badpc   <= exc_badpc;
                        cap_badaddr <= exc_badaddr;
                        // Nested exception keeps the original EPC.
                        skip_epc    <= exl;
                        cnt         <= CNT_INIT;
                        state       <= FLUSH;
                    end else if (eret) begin
                        state <= E_STATUS;
                    end
                end

                FLUSH: begin
                    flush <= 1'b1;
                    if (cnt == 8'd0) begin
                        state <= skip_epc ? W_CAUSE : W_EPC;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end

                W_EPC: begin
                    cp0_we    <= 1'b1;
                    cp0_waddr <= REG_EPC;
                    cp0_wdata <= cap_badpc;
                    state     <= W_CAUSE;
                end

                W_CAUSE: begin
                    cp0_we    <= 1'b1;
                    cp0_waddr <= REG_CAUSE;
                    cp0_wdata <= cap_cause;
                    state     <= W_STATUS;
                end

                W_STATUS: begin
                    cp0_we    <= 1'b1;
                    cp0_waddr <= REG_STATUS;
                    cp0_wdata <= cap_status | EXL_MASK;
                    exl       <= 1'b1;
                    // Address error load/store (ExcCode 4/5) also commits BadVAddr.
                    if (cap_code == 5'd4 || cap_code == 5'd5) begin
                        state <= W_BADV;
                    end else begin
                        state <= REDIR;
                    end
                end

                W_BADV: begin
                    cp0_we    <= 1'b1;
                    cp0_waddr <= REG_BADV;
                    cp0_wdata <= cap_badaddr;
                    state     <= REDIR;
                end

                REDIR: begin
                    flush       <= 1'b1;
                    pc_redirect <= 1'b1;
                    redirect_pc <= HANDLER_VEC;
                    state       <= IDLE;
                end

                E_STATUS: begin
                    flush     <= 1'b1;
                    cp0_we    <= 1'b1;
                    cp0_waddr <= REG_STATUS;
                    cp0_wdata <= status_q & ~EXL_MASK;
                    exl       <= 1'b0;
                    cap_epc   <= epc_q;
                    state     <= E_REDIR;
                end

                E_REDIR: begin
                    pc_redirect <= 1'b1;
                    redirect_pc <= cap_epc;
                    state       <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exception_sequencer.sv
// tb/tb_exception_sequencer.sv - directed self-checking bench for exception_sequencer
module tb_exception_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        except_req;
    logic [31:0] exc_cause;
    logic [31:0] exc_status;
    logic [31:0] exc_badpc;
    logic [31:0] exc_badaddr;
    logic        eret;
    logic [31:0] epc_q;
    logic [31:0] status_q;
    logic        busy;
    logic        flush;
    logic        cp0_we;
    logic [4:0]  cp0_waddr;
    logic [31:0] cp0_wdata;
    logic        pc_redirect;
    logic [31:0] redirect_pc;
    logic        exl;

    int tests_run = 0;
    int tests_failed = 0;

    exception_sequencer dut (
        .clk(clk),
        .rst(rst),
        .except_req(except_req),
        .exc_cause(exc_cause),
        .exc_status(exc_status),
        .exc_badpc(exc_badpc),
        .exc_badaddr(exc_badaddr),
        .eret(eret),
        .epc_q(epc_q),
        .status_q(status_q),
        .busy(busy),
        .flush(flush),
        .cp0_we(cp0_we),
        .cp0_waddr(cp0_waddr),
        .cp0_wdata(cp0_wdata),
        .pc_redirect(pc_redirect),
        .redirect_pc(redirect_pc),
        .exl(exl)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_out(input string tag, input logic b, input logic f, input logic we,
                           input logic [4:0] wa, input logic [31:0] wd,
                           input logic r, input logic [31:0] rp);
        check({tag, ".busy"}, 32'(busy), 32'(b));
        check({tag, ".flush"}, 32'(flush), 32'(f));
        check({tag, ".we"}, 32'(cp0_we), 32'(we));
        if (we) begin
            check({tag, ".waddr"}, 32'(cp0_waddr), 32'(wa));
            check({tag, ".wdata"}, cp0_wdata, wd);
        end
        check({tag, ".redir"}, 32'(pc_redirect), 32'(r));
        if (r) check({tag, ".rpc"}, redirect_pc, rp);
    endtask

    task automatic exp_idle(input string tag);
        exp_out(tag, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0);
    endtask

    // Drives one exception request and checks every cycle of the sequence.
    task automatic exc_seq(input string tag, input logic [31:0] cause, input logic [31:0] status,
                           input logic [31:0] badpc, input logic [31:0] badaddr,
                           input logic skip_epc, input logic badv, input logic with_eret,
                           input logic repulse);
        except_req  = 1'b1;
        eret        = with_eret;
        exc_cause   = cause;
        exc_status  = status;
        exc_badpc   = badpc;
        exc_badaddr = badaddr;
        step();
        eret = 1'b0;
        if (repulse) begin
            exc_cause = 32'h0000002c;
            exc_badpc = 32'h0badbad0;
        end else begin
            except_req = 1'b0;
        end
        exp_idle({tag, ".e0"});
        step();
        except_req = 1'b0;
        exp_out({tag, ".e1"}, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0);
        step();
        exp_out({tag, ".e2"}, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0);
        if (!skip_epc) begin
            step();
            exp_out({tag, ".epc"}, 1'b1, 1'b0, 1'b1, 5'd14, badpc, 1'b0, 32'd0);
        end
        step();
        exp_out({tag, ".cause"}, 1'b1, 1'b0, 1'b1, 5'd13, cause, 1'b0, 32'd0);
        step();
        exp_out({tag, ".status"}, 1'b1, 1'b0, 1'b1, 5'd12, status | 32'h2, 1'b0, 32'd0);
        if (badv) begin
            step();
            exp_out({tag, ".badv"}, 1'b1, 1'b0, 1'b1, 5'd8, badaddr, 1'b0, 32'd0);
        end
        step();
        exp_out({tag, ".redir"}, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 32'h00400004);
        step();
        exp_idle({tag, ".done"});
        check({tag, ".exl"}, 32'(exl), 32'd1);
        step();
        step();
        exp_idle({tag, ".quiet"});
    endtask

    task automatic eret_seq(input string tag, input logic [31:0] sq, input logic [31:0] eq,
                            input logic [31:0] exp_wd);
        status_q = sq;
        epc_q    = eq;
        eret     = 1'b1;
        step();
        eret = 1'b0;
        exp_idle({tag, ".e0"});
        step();
        exp_out({tag, ".status"}, 1'b1, 1'b1, 1'b1, 5'd12, exp_wd, 1'b0, 32'd0);
        check({tag, ".exl"}, 32'(exl), 32'd0);
        step();
        exp_out({tag, ".redir"}, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, eq);
        step();
        exp_idle({tag, ".done"});
    endtask

    initial begin
        rst         = 1'b1;
        except_req  = 1'b0;
        eret        = 1'b0;
        exc_cause   = '0;
        exc_status  = '0;
        exc_badpc   = '0;
        exc_badaddr = '0;
        epc_q       = '0;
        status_q    = '0;
        step();
        step();
        exp_idle("reset");
        check("reset.exl", 32'(exl), 32'd0);
        check("reset.rpc", redirect_pc, 32'd0);
        check("reset.wdata", cp0_wdata, 32'd0);
        rst = 1'b0;
        step();
        exp_idle("post_reset");

        // Overflow, no BadVAddr
        exc_seq("ovf", 32'h00000030, 32'h0000ff01, 32'h00400100, 32'h0,
                1'b0, 1'b0, 1'b0, 1'b0);

        // ERET clears EXL and returns to EPC
        eret_seq("eret1", 32'h0000ff03, 32'h00400200, 32'h0000ff01);

        // Address error load: BadVAddr write, redirect one cycle later
        exc_seq("adel", 32'h00000010, 32'h0000ff01, 32'h00400300, 32'h10000003,
                1'b0, 1'b1, 1'b0, 1'b0);

        // Masked interrupt with EXL set
        check("masked.exl_pre", 32'(exl), 32'd1);
        except_req = 1'b1;
        exc_cause  = 32'h00000000;
        for (int i = 0; i < 4; i++) begin
            step();
            exp_idle($sformatf("masked.c%0d", i));
        end
        except_req = 1'b0;

        // Break while EXL set: runs but skips EPC
        exc_seq("brk_nested", 32'h00000024, 32'h0000ff03, 32'h00400400, 32'h0,
                1'b1, 1'b0, 1'b0, 1'b0);

        eret_seq("eret2", 32'h0000ff13, 32'h00401000, 32'h0000ff11);

        // except_req + eret together: exception only; second pulse during FLUSH ignored
        exc_seq("collide", 32'h00000030, 32'h00000001, 32'h00400500, 32'h0,
                1'b0, 1'b0, 1'b1, 1'b1);

        eret_seq("eret3", 32'h00000003, 32'h00400600, 32'h00000001);

        // Reset while in W_CAUSE aborts the sequence
        except_req  = 1'b1;
        exc_cause   = 32'h00000014;
        exc_status  = 32'h0000ff01;
        exc_badpc   = 32'h00400700;
        exc_badaddr = 32'h20000001;
        step();
        except_req = 1'b0;
        step();
        step();
        step();
        exp_out("rst_mid.epc", 1'b1, 1'b0, 1'b1, 5'd14, 32'h00400700, 1'b0, 32'd0);
        rst = 1'b1;
        #1;
        exp_idle("rst_mid.async");
        check("rst_mid.exl", 32'(exl), 32'd0);
        step();
        #3;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            exp_idle($sformatf("rst_mid.after%0d", i));
        end
        check("rst_mid.exl_after", 32'(exl), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
